// File: rtl/fifo_rr_arbiter.sv
// Round-robin read scheduler: pops one of four source FIFOs per cycle and
// pushes the returned word into a shared output FIFO one cycle later.
module fifo_rr_arbiter #(
   parameter int TAMANO_DATOS    = 10,
   parameter int NUM_FIFOS       = 4,
   parameter int TAMANO_CONTADOR = 8
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              init,
   input  logic [NUM_FIFOS-1:0]              fifo_empty,
   input  logic [NUM_FIFOS*TAMANO_DATOS-1:0] fifo_data_out,
   input  logic                              out_almost_full,
   input  logic                              out_full,
   output logic [NUM_FIFOS-1:0]              fifo_read_enable,
   output logic                              out_write_enable,
   output logic [TAMANO_DATOS-1:0]           out_data_in,
   output logic [1:0]                        grant_idx,
   output logic [1:0]                        state,
   output logic                              idle,
   output logic                              error,
   output logic [TAMANO_CONTADOR-1:0]        contador
);

   typedef enum logic [1:0] {
      S_RESET  = 2'b00,
      S_INIT   = 2'b01,
      S_IDLE   = 2'b10,
      S_ACTIVE = 2'b11
   } state_t;

   state_t                     r_state;
   logic [1:0]                 r_rr_ptr;
   logic [1:0]                 r_grant_p1;
   logic                       r_vld_p1;
   logic                       r_error;
   logic [TAMANO_CONTADOR-1:0] r_cnt;

   logic                       w_run;
   logic                       w_pop_vld;
   logic [1:0]                 w_pop_idx;
   logic [1:0]                 w_cand;
   logic                       w_push;
   logic                       w_all_empty;
   logic [TAMANO_DATOS-1:0]    w_slice;

   assign w_run       = (r_state == S_IDLE) || (r_state == S_ACTIVE);
   assign w_all_empty = &fifo_empty;

   // Descending scan so the candidate closest after r_rr_ptr wins.
   always_comb begin
      w_pop_vld = 1'b0;
      w_pop_idx = 2'd0;
      w_cand    = 2'd0;
      if (w_run && !out_almost_full && !init) begin
         for (int k = NUM_FIFOS; k >= 1; k--) begin
            w_cand = r_rr_ptr + 2'(k);
            if (!fifo_empty[w_cand]) begin
               w_pop_vld = 1'b1;
               w_pop_idx = w_cand;
            end
         end
      end
   end

   assign fifo_read_enable = w_pop_vld ? (NUM_FIFOS'(1) << w_pop_idx) : '0;

   // Stage p1: source data_out is valid now for the FIFO popped last cycle.
   assign w_slice          = fifo_data_out[r_grant_p1*TAMANO_DATOS +: TAMANO_DATOS];
   assign w_push           = w_run && r_vld_p1 && !out_full && !init;
   assign out_write_enable = w_push;
   assign out_data_in      = r_vld_p1 ? w_slice : '0;

   assign grant_idx = r_grant_p1;
   assign state     = r_state;
   assign idle      = (r_state == S_IDLE);
   assign error     = r_error;
   assign contador  = r_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= S_RESET;
         r_rr_ptr   <= 2'd3;
         r_grant_p1 <= 2'd0;
         r_vld_p1   <= 1'b0;
         r_error    <= 1'b0;
         r_cnt      <= '0;
      end else begin
         case (r_state)
            S_RESET: r_state <= S_INIT;
            S_INIT: begin
               r_state  <= S_IDLE;
               r_cnt    <= '0;
               r_error  <= 1'b0;
               r_vld_p1 <= 1'b0;
               r_rr_ptr <= 2'd3;
            end
            default: begin
               if (init) begin
                  r_state  <= S_INIT;
                  r_vld_p1 <= 1'b0;
               end else begin
                  r_vld_p1 <= w_pop_vld;
                  if (w_pop_vld) begin
                     r_rr_ptr   <= w_pop_idx;
                     r_grant_p1 <= w_pop_idx;
                  end
                  if (w_push)
                     r_cnt <= r_cnt + TAMANO_CONTADOR'(1);
                  if (r_vld_p1 && out_full)
                     r_error <= 1'b1;
                  if (r_state == S_IDLE) begin
                     if (w_pop_vld)
                        r_state <= S_ACTIVE;
                  end else if (w_all_empty && !r_vld_p1) begin
                     r_state <= S_IDLE;
                  end
               end
            end
         endcase
      end
   end

endmodule
